// File: rtl/regfile_pkg.sv
// Shared register-file constants and the registered write-port record used by
// regfile_write_arbiter.
package regfile_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned NUM_REGS   = 32;

    localparam logic [REG_ADDR_W-1:0] REG_ZERO = '0;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [XLEN-1:0]       reg_data_t;

    // One registered write toward the register file.
    typedef struct packed {
        logic      we;
        reg_addr_t addr;
        reg_data_t data;
    } rf_wr_t;

    // Decodes a register address to a scoreboard mask; x0 never appears in the mask.
    function automatic logic [NUM_REGS-1:0] reg_mask(input reg_addr_t addr);
        logic [NUM_REGS-1:0] m;
        m       = '0;
        m[addr] = 1'b1;
        m[0]    = 1'b0;
        return m;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the search starts one past `last` and wraps
// modulo N; the pointer register lives in the parent.
module rr_arbiter #(
    parameter int unsigned N    = 3,
    parameter int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]    req,
    input  logic [IdxW-1:0] last,
    output logic [N-1:0]    grant,
    output logic [IdxW-1:0] grant_idx
);

    logic            found;
    int unsigned     cand;
    logic [IdxW-1:0] cand_idx;

    always_comb begin
        grant     = '0;
        grant_idx = last;
        found     = 1'b0;
        cand      = 0;
        cand_idx  = '0;
        for (int unsigned k = 1; k <= N; k++) begin
            cand = 32'(last) + k;
            if (cand >= N) begin
                cand = cand - N;
            end
            cand_idx = IdxW'(cand);
            if (!found && req[cand_idx]) begin
                found           = 1'b1;
                grant[cand_idx] = 1'b1;
                grant_idx       = cand_idx;
            end
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Round-robin sharing of the register-file write port plus a pending-write scoreboard.
// Defining RF_ARB_BYPASS_EN adds a combinational read bypass from the registered write.
module regfile_write_arbiter
    import regfile_pkg::*;
#(
    parameter int unsigned NUM_REQ = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*5-1:0]       req_addr,
    input  logic [NUM_REQ*32-1:0]      req_data,
    input  logic                       issue_valid,
    input  logic [REG_ADDR_W-1:0]      issue_rd,
    input  logic                       flush,
    output logic                       rf_we,
    output logic [REG_ADDR_W-1:0]      rf_waddr,
    output logic [XLEN-1:0]            rf_wdata,
    output logic [NUM_REGS-1:0]        busy
`ifdef RF_ARB_BYPASS_EN
    ,
    input  logic [REG_ADDR_W-1:0]      byp_raddr1,
    input  logic [REG_ADDR_W-1:0]      byp_raddr2,
    input  logic [XLEN-1:0]            rf_rdata1,
    input  logic [XLEN-1:0]            rf_rdata2,
    output logic [XLEN-1:0]            byp_rdata1,
    output logic [XLEN-1:0]            byp_rdata2
`endif
);

    localparam int unsigned IdxW = $clog2(NUM_REQ);

    logic [IdxW-1:0]     last_q, last_d;
    rf_wr_t              wr_q, wr_d;
    logic [NUM_REGS-1:0] busy_q, busy_d;

    logic [NUM_REQ-1:0]  arb_grant;
    logic [IdxW-1:0]     arb_idx;
    logic                xfer;
    reg_addr_t           sel_addr;
    reg_data_t           sel_data;

    rr_arbiter #(
        .N    (NUM_REQ),
        .IdxW (IdxW)
    ) u_rr_arbiter (
        .req       (req_valid),
        .last      (last_q),
        .grant     (arb_grant),
        .grant_idx (arb_idx)
    );

    // No grant is honoured while reset is held.
    always_comb begin
        req_ready = rst ? '0 : arb_grant;
        xfer      = |req_ready;
        sel_addr  = REG_ZERO;
        sel_data  = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (arb_grant[i]) begin
                sel_addr = req_addr[i*REG_ADDR_W +: REG_ADDR_W];
                sel_data = req_data[i*XLEN +: XLEN];
            end
        end
    end

    always_comb begin
        last_d = xfer ? arb_idx : last_q;

        // Address and data hold unless a real write is captured; x0 writes are consumed silently.
        wr_d    = wr_q;
        wr_d.we = 1'b0;
        if (xfer && (sel_addr != REG_ZERO)) begin
            wr_d.we   = 1'b1;
            wr_d.addr = sel_addr;
            wr_d.data = sel_data;
        end

        // Clear first so a same-edge issue to the same register (younger) wins.
        busy_d = busy_q;
        if (xfer) begin
            busy_d = busy_d & ~reg_mask(sel_addr);
        end
        if (issue_valid && (issue_rd != REG_ZERO)) begin
            busy_d = busy_d | reg_mask(issue_rd);
        end
        if (flush) begin
            busy_d = '0;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= IdxW'(NUM_REQ - 1);
            wr_q   <= '0;
            busy_q <= '0;
        end else begin
            last_q <= last_d;
            wr_q   <= wr_d;
            busy_q <= busy_d;
        end
    end

    always_comb begin
        rf_we    = wr_q.we;
        rf_waddr = wr_q.addr;
        rf_wdata = wr_q.data;
        busy     = busy_q;
    end

`ifdef RF_ARB_BYPASS_EN
    always_comb begin
        byp_rdata1 = rf_rdata1;
        byp_rdata2 = rf_rdata2;
        if (wr_q.we && (byp_raddr1 != REG_ZERO) && (wr_q.addr == byp_raddr1)) begin
            byp_rdata1 = wr_q.data;
        end
        if (wr_q.we && (byp_raddr2 != REG_ZERO) && (wr_q.addr == byp_raddr2)) begin
            byp_rdata2 = wr_q.data;
        end
    end
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: directed vector table, then random traffic
// against a rule-level reference model.
module tb_regfile_write_arbiter;

    localparam int N = 3;

    typedef struct {
        logic          rst;
        logic [N-1:0]  valid;
        logic [N*5-1:0]  addr;
        logic [N*32-1:0] data;
        logic          iv;
        logic [4:0]    rd;
        logic          fl;
        logic [N-1:0]  ready;
        logic          we;
        logic [4:0]    waddr;
        logic [31:0]   wdata;
        logic [31:0]   busy;
    } vec_t;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*5-1:0]  req_addr;
    logic [N*32-1:0] req_data;
    logic            issue_valid;
    logic [4:0]      issue_rd;
    logic            flush;
    logic            rf_we;
    logic [4:0]      rf_waddr;
    logic [31:0]     rf_wdata;
    logic [31:0]     busy;
`ifdef RF_ARB_BYPASS_EN
    logic [4:0]      byp_raddr1, byp_raddr2;
    logic [31:0]     rf_rdata1, rf_rdata2, byp_rdata1, byp_rdata2;
`endif

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state.
    int          m_last;
    logic        m_we;
    logic [4:0]  m_waddr;
    logic [31:0] m_wdata;
    logic [31:0] m_busy;

    always #5 clk = ~clk;

    regfile_write_arbiter #(
        .NUM_REQ (N)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_addr    (req_addr),
        .req_data    (req_data),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .flush       (flush),
        .rf_we       (rf_we),
        .rf_waddr    (rf_waddr),
        .rf_wdata    (rf_wdata),
        .busy        (busy)
`ifdef RF_ARB_BYPASS_EN
        ,
        .byp_raddr1  (byp_raddr1),
        .byp_raddr2  (byp_raddr2),
        .rf_rdata1   (rf_rdata1),
        .rf_rdata2   (rf_rdata2),
        .byp_rdata1  (byp_rdata1),
        .byp_rdata2  (byp_rdata2)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic r, input logic [N-1:0] v, input logic [N*5-1:0] a,
                                input logic [N*32-1:0] d, input logic iv, input logic [4:0] rd,
                                input logic fl, input logic [N-1:0] rdy, input logic we,
                                input logic [4:0] wa, input logic [31:0] wd,
                                input logic [31:0] b);
        vec_t t;
        t.rst = r;  t.valid = v;  t.addr = a;  t.data = d;
        t.iv = iv;  t.rd = rd;    t.fl = fl;   t.ready = rdy;
        t.we = we;  t.waddr = wa; t.wdata = wd; t.busy = b;
        return t;
    endfunction

    function automatic logic [N-1:0] model_grant(input vec_t v);
        logic [N-1:0] g;
        int idx;
        g = '0;
        if (!v.rst) begin
            for (int k = 1; k <= N; k++) begin
                idx = (m_last + k) % N;
                if (v.valid[idx] && g == '0) g[idx] = 1'b1;
            end
        end
        return g;
    endfunction

    task automatic model_edge(input vec_t v, input logic [N-1:0] g);
        logic [4:0] a;
        if (v.rst) begin
            m_last = N - 1; m_we = 1'b0; m_waddr = '0; m_wdata = '0; m_busy = '0;
            return;
        end
        m_we = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (g[i]) begin
                m_last = i;
                a = v.addr[i*5 +: 5];
                if (a != 0) begin
                    m_we = 1'b1; m_waddr = a; m_wdata = v.data[i*32 +: 32];
                end
                m_busy[a] = 1'b0;
            end
        end
        if (v.iv && v.rd != 0) m_busy[v.rd] = 1'b1;
        if (v.fl) m_busy = '0;
        m_busy[0] = 1'b0;
    endtask

    task automatic drive(input vec_t v);
        rst = v.rst; req_valid = v.valid; req_addr = v.addr; req_data = v.data;
        issue_valid = v.iv; issue_rd = v.rd; flush = v.fl;
    endtask

    // Applies one cycle; compares against the vector's own expectations or the model.
    task automatic step(input vec_t v, input bit use_tbl, output logic [N-1:0] g);
        logic [N-1:0] eg;
        drive(v);
        eg = model_grant(v);
        #3;
        chk("req_ready", 32'(req_ready), use_tbl ? 32'(v.ready) : 32'(eg));
        @(posedge clk);
        #1;
        model_edge(v, eg);
        chk("rf_we",    32'(rf_we),    use_tbl ? 32'(v.we)    : 32'(m_we));
        chk("rf_waddr", 32'(rf_waddr), use_tbl ? 32'(v.waddr) : 32'(m_waddr));
        chk("rf_wdata", rf_wdata,      use_tbl ? v.wdata      : m_wdata);
        chk("busy",     busy,          use_tbl ? v.busy       : m_busy);
        g = eg;
    endtask

    initial begin
        vec_t tbl[$];
        vec_t cur;
        logic [N-1:0] gp;
        logic [N*5-1:0]  a123;
        logic [N*32-1:0] d123;

        m_last = N - 1; m_we = 0; m_waddr = 0; m_wdata = 0; m_busy = 0;
`ifdef RF_ARB_BYPASS_EN
        byp_raddr1 = 0; byp_raddr2 = 0; rf_rdata1 = 0; rf_rdata2 = 0;
`endif
        a123 = {5'd3, 5'd2, 5'd1};
        d123 = {32'h33, 32'h22, 32'h11};

        //           rst valid  addr  data  iv rd fl  ready  we wa wdata  busy
        tbl.push_back(mk(1, 3'b111, a123, d123, 0, 0, 0, 3'b000, 0, 0, 32'h0, 32'h0));
        tbl.push_back(mk(0, 3'b111, a123, d123, 0, 0, 0, 3'b001, 1, 1, 32'h11, 32'h0));
        tbl.push_back(mk(0, 3'b111, a123, d123, 0, 0, 0, 3'b010, 1, 2, 32'h22, 32'h0));
        tbl.push_back(mk(0, 3'b111, a123, d123, 0, 0, 0, 3'b100, 1, 3, 32'h33, 32'h0));
        tbl.push_back(mk(0, 3'b111, a123, d123, 0, 0, 0, 3'b001, 1, 1, 32'h11, 32'h0));
        tbl.push_back(mk(0, 3'b000, a123, d123, 1, 5, 0, 3'b000, 0, 1, 32'h11, 32'h20));
        tbl.push_back(mk(0, 3'b010, {5'd0, 5'd5, 5'd0}, {32'h0, 32'hDEADBEEF, 32'h0},
                         0, 0, 0, 3'b010, 1, 5, 32'hDEADBEEF, 32'h0));
        tbl.push_back(mk(0, 3'b100, {5'd7, 5'd0, 5'd0}, {32'h77, 32'h0, 32'h0},
                         1, 7, 0, 3'b100, 1, 7, 32'h77, 32'h80));
        tbl.push_back(mk(0, 3'b100, {5'd0, 5'd0, 5'd0}, {32'h1234, 32'h0, 32'h0},
                         0, 0, 0, 3'b100, 0, 7, 32'h77, 32'h80));
        tbl.push_back(mk(0, 3'b000, '0, '0, 1, 3, 0, 3'b000, 0, 7, 32'h77, 32'h88));
        tbl.push_back(mk(0, 3'b000, '0, '0, 1, 9, 0, 3'b000, 0, 7, 32'h77, 32'h288));
        tbl.push_back(mk(0, 3'b000, '0, '0, 1, 4, 1, 3'b000, 0, 7, 32'h77, 32'h0));
        tbl.push_back(mk(0, 3'b001, {5'd0, 5'd0, 5'd10}, {32'h0, 32'h0, 32'hAA},
                         0, 0, 0, 3'b001, 1, 10, 32'hAA, 32'h0));
        tbl.push_back(mk(1, 3'b010, {5'd0, 5'd11, 5'd10}, {32'h0, 32'hBB, 32'hAA},
                         1, 6, 0, 3'b000, 0, 0, 32'h0, 32'h0));
        tbl.push_back(mk(0, 3'b011, {5'd0, 5'd11, 5'd10}, {32'h0, 32'hBB, 32'hAA},
                         0, 0, 0, 3'b001, 1, 10, 32'hAA, 32'h0));

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i], 1'b1, gp);
        end

`ifdef RF_ARB_BYPASS_EN
        cur = mk(0, 3'b001, {5'd0, 5'd0, 5'd6}, {32'h0, 32'h0, 32'hA5A5A5A5},
                 0, 0, 0, 3'b000, 0, 0, 32'h0, 32'h0);
        step(cur, 1'b0, gp);
        byp_raddr1 = 5'd6; rf_rdata1 = 32'h0;
        byp_raddr2 = 5'd0; rf_rdata2 = 32'h5A5A0001;
        #1;
        chk("byp_rdata1_hit", byp_rdata1, 32'hA5A5A5A5);
        chk("byp_rdata2_x0", byp_rdata2, 32'h5A5A0001);
        byp_raddr1 = 5'd7; rf_rdata1 = 32'h0BADF00D;
        byp_raddr2 = 5'd6;
        #1;
        chk("byp_rdata1_miss", byp_rdata1, 32'h0BADF00D);
        chk("byp_rdata2_hit", byp_rdata2, 32'hA5A5A5A5);
`endif

        // Random traffic: a requester keeps its address/data until granted.
        cur = mk(0, '0, '0, '0, 0, 0, 0, '0, 0, 0, 32'h0, 32'h0);
        gp = '0;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!cur.valid[i] || gp[i]) begin
                    cur.valid[i]       = ($urandom_range(0, 3) != 0);
                    cur.addr[i*5 +: 5] = 5'($urandom_range(0, 31));
                    cur.data[i*32 +: 32] = $urandom;
                end
            end
            cur.rst = ($urandom_range(0, 49) == 0);
            cur.iv  = 1'($urandom_range(0, 1));
            cur.rd  = 5'($urandom_range(0, 31));
            cur.fl  = ($urandom_range(0, 19) == 0);
            step(cur, 1'b0, gp);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/regfile_write_arbiter.md
# regfile_write_arbiter

Shares the single write port of `registerFile` among up to eight writeback requesters (ALU, load unit, mul/div, ...). A round-robin policy selects one requester per cycle, and the winning write is registered before it reaches `writeEnable`/`writeAddress`/`writeData`. The block also keeps a 32-bit pending-write scoreboard that issue logic uses for RAW hazard checks. It sits between the execute/memory writeback stages and the register file.

## Interface
- `NUM_REQ`, 3: number of writeback requesters, legal range 2..8.
- `clk`  in  1  rising-edge clock shared with the register file.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  NUM_REQ  requester i has a write pending.
- `req_ready`  out  NUM_REQ  one-hot grant; requester i's write is accepted this cycle.
- `req_addr`  in  NUM_REQ*5  flattened destination registers; requester i uses bits [5i+4:5i].
- `req_data`  in  NUM_REQ*32  flattened write data; requester i uses bits [32i+31:32i].
- `issue_valid`  in  1  an instruction writing `issue_rd` is issued this cycle.
- `issue_rd`  in  5  destination register of the issuing instruction.
- `flush`  in  1  clears the scoreboard; a write already registered still completes.
- `rf_we`  out  1  drives `writeEnable`.
- `rf_waddr`  out  5  drives `writeAddress`.
- `rf_wdata`  out  32  drives `writeData`.
- `busy`  out  32  scoreboard; bit r set means a write to xr is outstanding.

## Operation
- Arbitration:
  - Round-robin pointer `last` (log2 NUM_REQ bits) records the last granted index.
  - The search starts at `last+1` and wraps modulo NUM_REQ.
  - The first requester with `req_valid` high is granted.
  - `req_ready` is combinational from `req_valid` and `last`; at most one bit is high; all bits are low when no request is valid.
  - `last` updates only on a grant.
- Handshake:
  - A transfer occurs when `req_valid[i] && req_ready[i]`.
  - A requester holds its address and data stable until it is granted.
  - There is no backpressure from the register file.
- Write stage:
  - On a transfer with a nonzero address: `rf_we`=1 and `rf_waddr`/`rf_wdata` take the granted address and data on the next edge.
  - On a transfer with address 0: the write is consumed with `rf_we`=0.
  - With no transfer: `rf_we`=0, and `rf_waddr`/`rf_wdata` hold their last values.
- Scoreboard:
  - Set: `issue_valid` with a nonzero `issue_rd` sets `busy[issue_rd]`.
  - Clear: a transfer to address a clears `busy[a]` on the same edge the write is registered.
  - Set and clear to the same register on the same edge: set wins, because the issuing instruction is younger.
  - `flush` clears all bits and has priority over set.
  - `busy[0]` is constant 0.

## Timing
- Grant is combinational in the request cycle. The write appears on `rf_*` one cycle later, and the register file commits it on the following edge.
- Total latency from accepted request to visible register data is 2 edges. Sustained throughput is one write per cycle.
- `busy` changes on the same edge that registers the write.
- Reset values: `rf_we`=0, `rf_waddr`=0, `rf_wdata`=0, `busy`=0, and `last`=NUM_REQ-1, so requester 0 wins first.
- When `rst` is asserted mid-operation, the registered write is dropped (`rf_we`=0 the next cycle), the scoreboard is cleared, and no grant is honoured in the reset cycle.
- `req_ready` is forced to 0 while `rst` is high.

## Configuration
- `RF_ARB_BYPASS_EN` defined: the block adds the following ports.
  - Inputs `byp_raddr1`, `byp_raddr2` (5 bits each) and `rf_rdata1`, `rf_rdata2` (32 bits each).
  - Outputs `byp_rdata1`, `byp_rdata2` (32 bits each).
  - Each output returns `rf_wdata` when `rf_we` is high and `rf_waddr` equals the read address (address nonzero); otherwise it returns the register-file data. This path is purely combinational.
- `RF_ARB_BYPASS_EN` not defined: none of these ports exist, and consumers read `registerFile` directly, one cycle later than with the bypass.

## Structure
- Shared package/header `regfile_pkg` holds:
  - `XLEN`=32, `REG_ADDR_W`=5, `NUM_REGS`=32.
  - A `REG_ZERO` constant.
- Sub-module `rr_arbiter`, parameterised by N:
  - Inputs: `req` vector and `last` pointer.
  - Outputs: one-hot `grant` and encoded `grant_idx`.
  - Purely combinational; the pointer register stays in the parent.

## Test plan
- After reset, drive `req_valid`=3'b111 continuously with addresses 1/2/3. Required: grants 0,1,2,0,...; `rf_waddr` sequence 1,2,3,1 starting one cycle after each grant; `rf_we` stays 1.
- Assert `issue_valid` with `issue_rd`=5. Next cycle, requester 1 writes x5=0xDEADBEEF. Required: `busy[5]` goes 0→1→0; `rf_we`=1, `rf_waddr`=5, `rf_wdata`=0xDEADBEEF.
- In the same cycle, assert `issue_valid` with `issue_rd`=7 and a transfer to x7. Required: `busy[7]`=1 afterward.
- Requester 2 writes x0=0x1234. Required: `req_ready[2]`=1, `rf_we`=0, `busy[0]`=0.
- Set `busy` bits 3 and 9, then pulse `flush` together with `issue_valid`/`issue_rd`=4. Required: `busy`=0. Separately, assert `rst` the cycle after a grant. Required: `rf_we`=0 and requester 0 wins the next grant.
- With `RF_ARB_BYPASS_EN` defined and `rf_we`=1, `rf_waddr`=6, `rf_wdata`=0xA5A5A5A5:
  - `byp_raddr1`=6 with `rf_rdata1`=0 → `byp_rdata1`=0xA5A5A5A5.
  - `byp_raddr2`=0 → `byp_rdata2`=`rf_rdata2`.
